// File: rtl/pipe_pkg.sv
// Shared types and defaults for the fetch/decode pipeline stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  // Encoding doubles as the occupancy count of the skid stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  localparam int          PC_SIZE_DEF   = 18;
  localparam int          DATA_SIZE_DEF = 32;
  localparam logic [31:0] NOP_ENC       = 32'h0000_0000;

endpackage

// File: rtl/if_id_skid_stage_if.sv
// Fetch/decode handshake bundle for the IF/ID skid stage.
// Latency: n/a (wiring only).
// Backpressure: IF_ready from the stage, ID_ready from decode.
// Ports: IF_valid/IF_ready/IF_PC/IF_ir/IF_Flush on the fetch side,
//        ID_valid/ID_ready/ID_PC/ID_ir on the decode side.
interface if_id_skid_stage_if #(
  parameter int PC_SIZE   = 18,
  parameter int DATA_SIZE = 32
);
  logic                 IF_valid;
  logic                 IF_ready;
  logic [PC_SIZE-1:0]   IF_PC;
  logic [DATA_SIZE-1:0] IF_ir;
  logic                 IF_Flush;
  logic                 ID_valid;
  logic                 ID_ready;
  logic [PC_SIZE-1:0]   ID_PC;
  logic [DATA_SIZE-1:0] ID_ir;

  // Environment side: fetch drives the input, decode consumes the output.
  modport master (
    output IF_valid, IF_PC, IF_ir, IF_Flush, ID_ready,
    input  IF_ready, ID_valid, ID_PC, ID_ir
  );

  // Pipeline stage side.
  modport slave (
    input  IF_valid, IF_PC, IF_ir, IF_Flush, ID_ready,
    output IF_ready, ID_valid, ID_PC, ID_ir
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter for stage statistics.
// Latency: count updates on the edge after inc is sampled.
// Backpressure: none; holds at all-ones once saturated.
// Ports: clk, rst (sync, active high), inc (increment enable), cnt (count).
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with a 2-entry skid buffer and flush.
// Latency: 1 cycle from input transfer to ID_valid; no comb path in->out.
// Backpressure: IF_ready is registered and drops only when both entries are full.
// Ports: clk, rst (sync, active high), bus (handshake bundle, slave side),
//        occupancy (entries held), flush_cnt (flushes that killed live entries).
module if_id_skid_stage
  import pipe_pkg::*;
#(
  parameter int                   PC_SIZE   = PC_SIZE_DEF,
  parameter int                   DATA_SIZE = DATA_SIZE_DEF,
  parameter logic [DATA_SIZE-1:0] NOP_IR    = DATA_SIZE'(NOP_ENC),
  parameter int                   CNT_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  if_id_skid_stage_if.slave   bus,
  output logic [1:0]          occupancy,
  output logic [CNT_W-1:0]    flush_cnt
);

  skid_state_t          state_q, state_d;
  logic [PC_SIZE-1:0]   m_pc_q, m_pc_d, s_pc_q, s_pc_d;
  logic [DATA_SIZE-1:0] m_ir_q, m_ir_d, s_ir_q, s_ir_d;
  logic                 if_ready_q;
  logic                 in_xfer, out_xfer, flush_hit;

  assign in_xfer   = bus.IF_valid && if_ready_q;
  assign out_xfer  = (state_q != EMPTY) && bus.ID_ready;
  assign flush_hit = bus.IF_Flush && (state_q != EMPTY);

  // Next-state and datapath. M is cleared whenever the stage drains so the
  // outputs can be driven straight from the register without a valid mux.
  always_comb begin
    state_d = state_q;
    m_pc_d  = m_pc_q;
    m_ir_d  = m_ir_q;
    s_pc_d  = s_pc_q;
    s_ir_d  = s_ir_q;

    if (bus.IF_Flush) begin
      state_d = EMPTY;
      m_pc_d  = '0;
      m_ir_d  = NOP_IR;
      s_pc_d  = '0;
      s_ir_d  = NOP_IR;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            m_pc_d  = bus.IF_PC;
            m_ir_d  = bus.IF_ir;
          end
        end
        ONE: begin
          unique case ({in_xfer, out_xfer})
            2'b10: begin
              state_d = TWO;
              s_pc_d  = bus.IF_PC;
              s_ir_d  = bus.IF_ir;
            end
            2'b01: begin
              state_d = EMPTY;
              m_pc_d  = '0;
              m_ir_d  = NOP_IR;
            end
            2'b11: begin
              m_pc_d = bus.IF_PC;
              m_ir_d = bus.IF_ir;
            end
            default: ;
          endcase
        end
        TWO: begin
          // IF_ready is low here, so only the drain side can move.
          if (out_xfer) begin
            state_d = ONE;
            m_pc_d  = s_pc_q;
            m_ir_d  = s_ir_q;
            s_pc_d  = '0;
            s_ir_d  = NOP_IR;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      m_pc_q     <= '0;
      m_ir_q     <= NOP_IR;
      s_pc_q     <= '0;
      s_ir_q     <= NOP_IR;
      if_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_pc_q     <= m_pc_d;
      m_ir_q     <= m_ir_d;
      s_pc_q     <= s_pc_d;
      s_ir_q     <= s_ir_d;
      // Registered copy of (state != TWO) so fetch never sees decode timing.
      if_ready_q <= (state_d != TWO);
    end
  end

  assign bus.IF_ready = if_ready_q;
  assign bus.ID_valid = (state_q != EMPTY);
  assign bus.ID_PC    = m_pc_q;
  assign bus.ID_ir    = m_ir_q;
  assign occupancy    = state_q;

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_hit),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Bench for if_id_skid_stage: FIFO reference model plus vector table.
// Latency: n/a.
// Backpressure: n/a.
module tb_if_id_skid_stage;

  localparam int          PCW  = 18;
  localparam int          DW   = 32;
  localparam int          CW   = 2;
  localparam logic [31:0] NOPV = 32'h0;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic [DW-1:0]  ir;
  } ent_t;

  typedef struct packed {
    logic           rst;
    logic           vld;
    logic [PCW-1:0] pc;
    logic           flush;
    logic           rdy;
    logic           exp_vld;
    logic [PCW-1:0] exp_pc;
    logic [1:0]     exp_occ;
    logic           exp_if_rdy;
    logic [CW-1:0]  exp_cnt;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    occupancy;
  logic [CW-1:0] flush_cnt;

  if_id_skid_stage_if #(.PC_SIZE(PCW), .DATA_SIZE(DW)) b ();

  if_id_skid_stage #(
    .PC_SIZE(PCW), .DATA_SIZE(DW), .NOP_IR(NOPV), .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (b),
    .occupancy (occupancy),
    .flush_cnt (flush_cnt)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  ent_t          mq[$];       // scoreboard: entries expected on ID, oldest first
  logic [CW-1:0] cnt_m = '0;
  vec_t          tv[14];

  function automatic logic [DW-1:0] ir_of(input logic [PCW-1:0] pc);
    return 32'hA500_0000 | 32'(pc);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic            ev;
    logic [PCW-1:0]  epc;
    logic [DW-1:0]   eir;
    ev  = (mq.size() > 0);
    epc = ev ? mq[0].pc : '0;
    eir = ev ? mq[0].ir : NOPV;
    chk("id_valid",  32'(b.ID_valid),  32'(ev));
    chk("id_pc",     32'(b.ID_PC),     32'(epc));
    chk("id_ir",     b.ID_ir,          eir);
    chk("occupancy", 32'(occupancy),   32'(mq.size()));
    chk("if_ready",  32'(b.IF_ready),  32'(mq.size() < 2));
    chk("flush_cnt", 32'(flush_cnt),   32'(cnt_m));
    if (!b.ID_valid) chk("nop_when_invalid", b.ID_ir, NOPV);
  endtask

  // Drive one cycle, advance the reference model across the edge, then check.
  task automatic step(input logic r, input logic v, input logic [PCW-1:0] pc,
                      input logic [DW-1:0] ir, input logic f, input logic rdy);
    logic acc, cons;
    rst        = r;
    b.IF_valid = v;
    b.IF_PC    = pc;
    b.IF_ir    = ir;
    b.IF_Flush = f;
    b.ID_ready = rdy;
    acc  = v && (mq.size() < 2) && !f && !r;
    cons = (mq.size() > 0) && rdy && !r;
    if (r) cnt_m = '0;
    else if (f && (mq.size() > 0) && (cnt_m != '1)) cnt_m = cnt_m + 1'b1;
    @(posedge clk);
    if (r || f) begin
      mq.delete();
    end else begin
      if (cons) void'(mq.pop_front());
      if (acc) mq.push_back('{pc: pc, ir: ir});
    end
    #1;
    check_model();
  endtask

  task automatic stepp(input logic r, input logic v, input logic [PCW-1:0] pc,
                       input logic f, input logic rdy);
    step(r, v, pc, ir_of(pc), f, rdy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int             nextpc;
    logic           pend;
    logic [PCW-1:0] cur;
    logic           v, f, rdy, acc;

    //            rst  vld  pc      fl   rdy  e_v  e_pc    occ   if_r e_cnt
    tv[0]  = '{1'b1, 1'b0, 18'd0,  1'b0, 1'b0, 1'b0, 18'd0,  2'd0, 1'b1, 2'd0};
    tv[1]  = '{1'b0, 1'b1, 18'd8,  1'b0, 1'b0, 1'b1, 18'd8,  2'd1, 1'b1, 2'd0};
    tv[2]  = '{1'b0, 1'b1, 18'd12, 1'b0, 1'b0, 1'b1, 18'd8,  2'd2, 1'b0, 2'd0};
    tv[3]  = '{1'b0, 1'b1, 18'd16, 1'b0, 1'b0, 1'b1, 18'd8,  2'd2, 1'b0, 2'd0};
    tv[4]  = '{1'b0, 1'b1, 18'd16, 1'b0, 1'b1, 1'b1, 18'd12, 2'd1, 1'b1, 2'd0};
    tv[5]  = '{1'b0, 1'b1, 18'd16, 1'b0, 1'b1, 1'b1, 18'd16, 2'd1, 1'b1, 2'd0};
    tv[6]  = '{1'b0, 1'b0, 18'd0,  1'b0, 1'b1, 1'b0, 18'd0,  2'd0, 1'b1, 2'd0};
    tv[7]  = '{1'b0, 1'b1, 18'd20, 1'b0, 1'b0, 1'b1, 18'd20, 2'd1, 1'b1, 2'd0};
    tv[8]  = '{1'b0, 1'b1, 18'd24, 1'b0, 1'b0, 1'b1, 18'd20, 2'd2, 1'b0, 2'd0};
    tv[9]  = '{1'b0, 1'b1, 18'd40, 1'b1, 1'b0, 1'b0, 18'd0,  2'd0, 1'b1, 2'd1};
    tv[10] = '{1'b0, 1'b0, 18'd0,  1'b0, 1'b0, 1'b0, 18'd0,  2'd0, 1'b1, 2'd1};
    tv[11] = '{1'b0, 1'b0, 18'd0,  1'b1, 1'b0, 1'b0, 18'd0,  2'd0, 1'b1, 2'd1};
    tv[12] = '{1'b0, 1'b1, 18'd44, 1'b0, 1'b0, 1'b1, 18'd44, 2'd1, 1'b1, 2'd1};
    tv[13] = '{1'b0, 1'b0, 18'd0,  1'b1, 1'b1, 1'b0, 18'd0,  2'd0, 1'b1, 2'd2};

    b.IF_valid = 1'b0; b.IF_PC = '0; b.IF_ir = '0; b.IF_Flush = 1'b0; b.ID_ready = 1'b0;

    // Reset held 3 cycles with a word offered; first word lands 1 cycle after release.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 18'd5, 32'h20080005, 1'b0, 1'b0);
    step(1'b0, 1'b1, 18'd5, 32'h20080005, 1'b0, 1'b0);
    chk("first_word_ir", b.ID_ir, 32'h20080005);
    stepp(1'b0, 1'b0, 18'd0, 1'b0, 1'b1);

    // Streaming: 8 back-to-back words, no bubbles, occupancy stays 1.
    for (int i = 0; i < 8; i++) begin
      stepp(1'b0, 1'b1, 18'(4 * i), 1'b0, 1'b1);
      chk("stream_pc", 32'(b.ID_PC), 32'(4 * i));
      chk("stream_occ", 32'(occupancy), 32'd1);
    end
    stepp(1'b0, 1'b0, 18'd0, 1'b0, 1'b1);

    // Vector table: stall/skid, full-buffer flush, empty flush, flush+consume.
    for (int i = 0; i < 14; i++) begin
      stepp(tv[i].rst, tv[i].vld, tv[i].pc, tv[i].flush, tv[i].rdy);
      chk($sformatf("tv%0d_vld", i), 32'(b.ID_valid),  32'(tv[i].exp_vld));
      chk($sformatf("tv%0d_pc", i),  32'(b.ID_PC),     32'(tv[i].exp_pc));
      chk($sformatf("tv%0d_occ", i), 32'(occupancy),   32'(tv[i].exp_occ));
      chk($sformatf("tv%0d_rdy", i), 32'(b.IF_ready),  32'(tv[i].exp_if_rdy));
      chk($sformatf("tv%0d_cnt", i), 32'(flush_cnt),   32'(tv[i].exp_cnt));
    end

    // Saturation: 5 flushes on a nonempty buffer with a 2-bit counter.
    stepp(1'b1, 1'b0, 18'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      stepp(1'b0, 1'b1, 18'(100 + 4 * i), 1'b0, 1'b0);
      stepp(1'b0, 1'b0, 18'd0, 1'b1, 1'b0);
    end
    chk("sat_cnt", 32'(flush_cnt), 32'd3);

    // Reset mid-stall together with flush: reset wins, counter cleared.
    stepp(1'b0, 1'b1, 18'd200, 1'b0, 1'b0);
    stepp(1'b0, 1'b1, 18'd204, 1'b0, 1'b0);
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    stepp(1'b1, 1'b1, 18'd208, 1'b1, 1'b0);
    chk("rst_cnt", 32'(flush_cnt), 32'd0);
    chk("rst_vld", 32'(b.ID_valid), 32'd0);
    chk("rst_rdy", 32'(b.IF_ready), 32'd1);

    // Random traffic against the FIFO model; offered word held until taken.
    nextpc = 1000;
    pend   = 1'b0;
    cur    = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pend) begin
        cur    = 18'(nextpc);
        nextpc = nextpc + 4;
      end
      v   = pend || ($urandom_range(0, 3) != 0);
      f   = ($urandom_range(0, 19) == 0);
      rdy = $urandom_range(0, 1) != 0;
      acc = v && (mq.size() < 2) && !f;
      stepp(1'b0, v, cur, f, rdy);
      pend = v && !acc && !f;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
